hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter: FLUSH_CYCLES, 1, number of cycles the IF_ID and ID_EX registers are flushed after a taken branch (legal 1..3).
REQ-002 SHALL have port: CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: IDRs1, IDRs2  input  16  source register indices of the instruction in decode.
REQ-005 SHALL have ports: IDUsesRs1, IDUsesRs2  input  1  decode instruction reads Rs1 / Rs2.
REQ-006 SHALL have ports: EXRd  input  16 and EXMemRead  input  1  destination and load flag of the instruction in ID_EX.
REQ-007 SHALL have port: BranchTaken  input  1  taken branch resolved in EX this cycle.
REQ-008 SHALL have port: MemBusy  input  1  data memory not ready; the whole pipeline freezes.
REQ-009 SHALL have ports: PCWrite, IFIDWrite, IDEXWrite  output  1  stage enables; IDEXWrite drives the ID_EX RegWrite input.
REQ-010 SHALL have ports: IFIDFlush, IDEXFlush  output  1  zero the stage register; IDEXFlush is ORed into the ID_EX Reset input.
REQ-011 SHALL have ports: StallCount, FlushCount  output  16  performance counters (see Configuration).

Function
REQ-012 SHALL implement FSM states RUN, MEMWAIT, FLUSH, held in a registered state plus a 2-bit flush counter and a 1-bit BranchPending flag.
REQ-013 Outputs SHALL be combinational from current state and inputs; state, counter and flags SHALL be registered.
REQ-014 Priority per cycle SHALL be: Reset > MemBusy > BranchTaken or BranchPending > load-use hazard > normal.
REQ-015 Load-use hazard SHALL be: EXMemRead=1, EXRd!=0, and (IDUsesRs1 and IDRs1==EXRd, or IDUsesRs2 and IDRs2==EXRd).
REQ-016 Register index 0 SHALL never cause a hazard.
REQ-017 In RUN with a hazard: PCWrite=0, IFIDWrite=0, IDEXWrite=1, IDEXFlush=1 (one bubble); the state SHALL stay RUN; the hazard clears naturally the next cycle.
REQ-018 In RUN with no event: PCWrite=IFIDWrite=IDEXWrite=1, both flushes 0.
REQ-019 MemBusy=1 in any state SHALL force PCWrite=IFIDWrite=IDEXWrite=0 and both flushes 0; the state SHALL go to MEMWAIT and the flush counter SHALL freeze.
REQ-020 BranchTaken=1 while MemBusy=1 SHALL set BranchPending; no flush SHALL occur until MemBusy=0.
REQ-021 Leaving MEMWAIT (MemBusy=0) SHALL return to FLUSH if BranchPending or the counter is nonzero, else to RUN.
REQ-022 BranchTaken (or BranchPending) with MemBusy=0 SHALL assert IFIDFlush=IDEXFlush=1 and PCWrite=IFIDWrite=IDEXWrite=1 that cycle; load the counter with FLUSH_CYCLES-1; clear BranchPending; and go to FLUSH if the loaded value is nonzero, else to RUN.
REQ-023 In FLUSH: both flushes SHALL be 1 and all enables 1; the counter SHALL decrement; at 0 the state SHALL go to RUN.
REQ-024 In FLUSH, load-use hazards SHALL be ignored, because the decode instruction is being squashed.
REQ-025 A new BranchTaken in FLUSH SHALL reload the counter with FLUSH_CYCLES-1.
REQ-026 FLUSH_CYCLES outside 1..3 SHALL be clamped to 3 by the implementation.

Reset
REQ-027 On Reset=1 at a clock edge: state=RUN, counter=0, BranchPending=0, StallCount=0, FlushCount=0.
REQ-028 While Reset=1, outputs SHALL be PCWrite=IFIDWrite=IDEXWrite=0, IFIDFlush=IDEXFlush=1.
REQ-029 Reset mid-MEMWAIT or mid-FLUSH SHALL discard the pending branch and any remaining flush cycles.

Configuration
REQ-030 Macro HAZARD_CTRL_PERF_EN defined: StallCount SHALL increment on each load-use bubble or MemBusy cycle; FlushCount SHALL increment on each cycle with IDEXFlush=1 outside reset; both SHALL saturate at 16'hFFFF.
REQ-031 Macro HAZARD_CTRL_PERF_EN undefined: StallCount and FlushCount SHALL be constant 0 and no counter flops SHALL exist.

Verification
REQ-032 EXMemRead=1, EXRd=5, IDRs2=5, IDUsesRs2=1 -> exactly one cycle with PCWrite=0, IFIDWrite=0, IDEXFlush=1; StallCount=1 (PERF_EN).
REQ-033 Same as REQ-032 but EXRd=0 -> no stall; all enables 1.
REQ-034 FLUSH_CYCLES=2, BranchTaken pulse -> IFIDFlush=IDEXFlush=1 for exactly 2 cycles, then RUN; FlushCount=2.
REQ-035 MemBusy=1 for 3 cycles with a BranchTaken pulse in the 2nd -> 3 frozen cycles with no flush, then flush starts in the first cycle after MemBusy=0.
REQ-036 Reset asserted in the 2nd cycle of a 3-cycle FLUSH -> next cycle in RUN with enables 1; both counters 0.
REQ-037 Load-use hazard present during FLUSH -> no stall (PCWrite=1); StallCount unchanged.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use stalls, branch flushes, memory freeze
//
// Purpose: generates the stage enables and flushes for a 5-stage pipeline.
//   Per-cycle priority: Reset > MemBusy > taken/pending branch > load-use hazard > normal.
//   A taken branch flushes IF_ID and ID_EX for FLUSH_CYCLES cycles. Values outside
//   1..3 are clamped to 3. A branch that resolves while memory is busy is remembered
//   and flushed once the freeze lifts.
//
// Optional feature: define HAZARD_CTRL_PERF_EN to build the saturating StallCount and
//   FlushCount performance counters. Without it, both outputs are tied to zero.
//
// Ports:
//   CLK                     in   clock, rising edge
//   Reset                   in   synchronous active-high reset
//   IDRs1, IDRs2 [15:0]     in   decode-stage source register indices
//   IDUsesRs1, IDUsesRs2    in   decode instruction reads Rs1 / Rs2
//   EXRd [15:0], EXMemRead  in   destination and load flag of the ID_EX instruction
//   BranchTaken             in   taken branch resolved in EX this cycle
//   MemBusy                 in   data memory not ready, freeze everything
//   PCWrite, IFIDWrite,     out  stage register enables
//   IDEXWrite
//   IFIDFlush, IDEXFlush    out  zero the stage register
//   StallCount, FlushCount  out  performance counters [15:0]

module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [15:0] IDRs1,
  input  logic [15:0] IDRs2,
  input  logic        IDUsesRs1,
  input  logic        IDUsesRs2,
  input  logic [15:0] EXRd,
  input  logic        EXMemRead,
  input  logic        BranchTaken,
  input  logic        MemBusy,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEXWrite,
  output logic        IFIDFlush,
  output logic        IDEXFlush,
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount
);

  localparam int         FC_EFF = (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3) ? 3 : FLUSH_CYCLES;
  // The branch cycle itself is the first flush cycle, so the counter holds the remainder.
  localparam logic [1:0] RELOAD = 2'(FC_EFF - 1);

  typedef enum logic [1:0] {RUN, MEMWAIT, FLUSH} state_t;

  state_t     state, state_n;
  logic [1:0] cnt, cnt_n;
  logic       pend, pend_n;
  logic       load_use;

  assign load_use = EXMemRead && (EXRd != 16'd0) &&
                    ((IDUsesRs1 && (IDRs1 == EXRd)) || (IDUsesRs2 && (IDRs2 == EXRd)));

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= RUN;
      cnt   <= 2'd0;
      pend  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pend  <= pend_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pend_n    = pend;
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IDEXWrite = 1'b1;
    IFIDFlush = 1'b0;
    IDEXFlush = 1'b0;
    if (Reset) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IDEXWrite = 1'b0;
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
      state_n   = RUN;
      cnt_n     = 2'd0;
      pend_n    = 1'b0;
    end else if (MemBusy) begin
      // Full freeze: nothing moves, the flush counter holds, a branch is only remembered.
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IDEXWrite = 1'b0;
      state_n   = MEMWAIT;
      if (BranchTaken) pend_n = 1'b1;
    end else if (BranchTaken || pend) begin
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
      cnt_n     = RELOAD;
      pend_n    = 1'b0;
      state_n   = (RELOAD != 2'd0) ? FLUSH : RUN;
    end else if (state != RUN && cnt != 2'd0) begin
      // FLUSH, or the first free cycle after a freeze that interrupted a flush: the
      // remaining squash cycles resume immediately so no wrong-path instruction slips
      // through. Load-use hazards are moot because decode is being squashed.
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
      cnt_n     = cnt - 2'd1;
      state_n   = (cnt == 2'd1) ? RUN : FLUSH;
    end else if (load_use) begin
      // One bubble: hold PC and IF_ID, insert a zeroed ID_EX.
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IDEXFlush = 1'b1;
      state_n   = RUN;
    end else begin
      state_n   = RUN;
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [15:0] stall_q, flush_q;
  logic        stall_evt, flush_evt;

  // Outside reset, PCWrite drops only for a freeze or a load-use bubble.
  assign stall_evt = !Reset && !PCWrite;
  assign flush_evt = !Reset && IDEXFlush;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      if (stall_evt && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      if (flush_evt && flush_q != 16'hFFFF) flush_q <= flush_q + 16'd1;
    end
  end

  assign StallCount = stall_q;
  assign FlushCount = flush_q;
`else
  assign StallCount = 16'd0;
  assign FlushCount = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl (three FLUSH_CYCLES builds side by side)

module tb_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [15:0] IDRs1, IDRs2, EXRd;
  logic        IDUsesRs1, IDUsesRs2, EXMemRead, BranchTaken, MemBusy;

  // ctl = {PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXFlush}
  logic [2:0][4:0]  ctl;
  logic [2:0][15:0] sc;
  logic [2:0][15:0] fcn;

  int fce  [3] = '{1, 2, 3};   // effective flush lengths; instance 2 uses 5, clamped to 3
  int rem  [3];
  int pend [3];
  int scnt [3];
  int fcnt [3];
  bit cnt_valid = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_ctrl #(.FLUSH_CYCLES(g == 0 ? 1 : (g == 1 ? 2 : 5))) u_dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .IDRs1      (IDRs1),
      .IDRs2      (IDRs2),
      .IDUsesRs1  (IDUsesRs1),
      .IDUsesRs2  (IDUsesRs2),
      .EXRd       (EXRd),
      .EXMemRead  (EXMemRead),
      .BranchTaken(BranchTaken),
      .MemBusy    (MemBusy),
      .PCWrite    (ctl[g][4]),
      .IFIDWrite  (ctl[g][3]),
      .IDEXWrite  (ctl[g][2]),
      .IFIDFlush  (ctl[g][1]),
      .IDEXFlush  (ctl[g][0]),
      .StallCount (sc[g]),
      .FlushCount (fcn[g])
    );
  end

  // One clock cycle: drive inputs after the falling edge, check combinational
  // outputs and registered counters, then advance the reference model.
  task automatic cyc(input bit rst, input bit busy, input bit br, input bit emr,
                     input logic [15:0] rd, input logic [15:0] r1, input logic [15:0] r2,
                     input bit u1, input bit u2);
    logic [4:0] exp_ctl;
    bit         haz;
    int         es, ef;
    @(negedge CLK);
    Reset = rst; MemBusy = busy; BranchTaken = br; EXMemRead = emr;
    EXRd = rd; IDRs1 = r1; IDRs2 = r2; IDUsesRs1 = u1; IDUsesRs2 = u2;
    #1;
    haz = emr && (rd != 16'd0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
    for (int k = 0; k < 3; k++) begin
`ifdef HAZARD_CTRL_PERF_EN
      es = scnt[k];
      ef = fcnt[k];
`else
      es = 0;
      ef = 0;
`endif
      if (cnt_valid) begin
        vectors++;
        assert (sc[k] === 16'(es)) else begin
          miscompares++;
          $error("FAIL stall_count dut%0d observed=%0d expected=%0d", k, sc[k], es);
        end
        vectors++;
        assert (fcn[k] === 16'(ef)) else begin
          miscompares++;
          $error("FAIL flush_count dut%0d observed=%0d expected=%0d", k, fcn[k], ef);
        end
      end

      if (rst) begin
        exp_ctl = 5'b00011;
        rem[k] = 0; pend[k] = 0; scnt[k] = 0; fcnt[k] = 0;
      end else if (busy) begin
        exp_ctl = 5'b00000;
        if (br) pend[k] = 1;
      end else if (br || pend[k] != 0) begin
        exp_ctl = 5'b11111;
        rem[k]  = fce[k] - 1;
        pend[k] = 0;
      end else if (rem[k] > 0) begin
        exp_ctl = 5'b11111;
        rem[k]--;
      end else if (haz) begin
        exp_ctl = 5'b00101;
      end else begin
        exp_ctl = 5'b11100;
      end
      if (!rst) begin
        if (!exp_ctl[4] && scnt[k] < 65535) scnt[k]++;
        if (exp_ctl[0] && fcnt[k] < 65535) fcnt[k]++;
      end

      vectors++;
      assert (ctl[k] === exp_ctl) else begin
        miscompares++;
        $error("FAIL controls dut%0d observed=%b expected=%b", k, ctl[k], exp_ctl);
      end
    end
    if (rst) cnt_valid = 1'b1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 16'd0, 16'd0, 16'd0, 0, 0);
  endtask

  initial begin
    Reset = 1'b1; MemBusy = 1'b0; BranchTaken = 1'b0; EXMemRead = 1'b0;
    EXRd = '0; IDRs1 = '0; IDRs2 = '0; IDUsesRs1 = 1'b0; IDUsesRs2 = 1'b0;

    cyc(1, 0, 0, 0, 16'd0, 16'd0, 16'd0, 0, 0);
    cyc(1, 1, 1, 1, 16'd3, 16'd3, 16'd3, 1, 1);
    idle();

    // Load-use on Rs2: a single bubble, then the load has moved on.
    cyc(0, 0, 0, 1, 16'd5, 16'd0, 16'd5, 0, 1);
    cyc(0, 0, 0, 0, 16'd0, 16'd0, 16'd5, 0, 1);
    idle();

    // Destination 0 never stalls.
    cyc(0, 0, 0, 1, 16'd0, 16'd0, 16'd0, 1, 1);
    idle();

    // Branch pulse, then quiet cycles while the flush window runs out.
    cyc(0, 0, 1, 0, 16'd0, 16'd0, 16'd0, 0, 0);
    repeat (3) idle();

    // Three frozen cycles with a branch in the middle, flush starts after the freeze.
    cyc(0, 1, 0, 0, 16'd0, 16'd0, 16'd0, 0, 0);
    cyc(0, 1, 1, 0, 16'd0, 16'd0, 16'd0, 0, 0);
    cyc(0, 1, 0, 0, 16'd0, 16'd0, 16'd0, 0, 0);
    repeat (4) idle();

    // Reset in the second flush cycle drops the rest of the flush.
    cyc(0, 0, 1, 0, 16'd0, 16'd0, 16'd0, 0, 0);
    cyc(1, 0, 0, 0, 16'd0, 16'd0, 16'd0, 0, 0);
    idle();
    idle();

    // Load-use during flush is ignored.
    cyc(0, 0, 1, 0, 16'd0, 16'd0, 16'd0, 0, 0);
    cyc(0, 0, 0, 1, 16'd7, 16'd7, 16'd0, 1, 0);
    cyc(0, 0, 0, 1, 16'd7, 16'd7, 16'd7, 1, 1);
    idle();

    // Freeze in the middle of a flush, then a re-branch during flush.
    cyc(0, 0, 1, 0, 16'd0, 16'd0, 16'd0, 0, 0);
    cyc(0, 1, 0, 0, 16'd0, 16'd0, 16'd0, 0, 0);
    cyc(0, 1, 0, 0, 16'd0, 16'd0, 16'd0, 0, 0);
    idle();
    cyc(0, 0, 1, 0, 16'd0, 16'd0, 16'd0, 0, 0);
    cyc(0, 0, 1, 0, 16'd0, 16'd0, 16'd0, 0, 0);
    repeat (4) idle();

    for (int i = 0; i < 500; i++) begin
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
          $urandom_range(0, 1) == 1, 16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)),
          16'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
